// File: rtl/cdc_cmd_feeder_pkg.sv
// Shared definitions for the command feeder: default sizes, the launch FSM
// state type and the packed {addr,data} command layout.
package cdc_cmd_feeder_pkg;

   localparam int AW_DEFAULT    = 4;
   localparam int DW_DEFAULT    = 8;
   localparam int DEPTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      GUARD = 2'd2,
      WAIT  = 2'd3
   } feeder_state_t;

   typedef struct packed {
      logic [AW_DEFAULT-1:0] addr;
      logic [DW_DEFAULT-1:0] data;
   } cmd_t;

endpackage

// File: rtl/cdc_cmd_fifo.sv
// Command queue for the feeder: storage, wrapping pointers, occupancy and,
// when CDC_CMD_FEEDER_COALESCE_EN is defined, in-place address coalescing.
module cdc_cmd_fifo
   import cdc_cmd_feeder_pkg::*;
#(
   parameter int AW    = AW_DEFAULT,
   parameter int DW    = DW_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                     src_clk,
   input  logic                     src_resetn,
   input  logic                     wr_valid,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DW-1:0]            wr_data,
   output logic                     wr_ready,
   input  logic                     pop,
   output logic [AW+DW-1:0]         head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          hit;
   logic [PW-1:0] hit_idx;
   logic          accept;
   logic          push;
   logic          overwrite;

   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);
   assign head  = {addr_mem[rd_ptr], data_mem[rd_ptr]};

`ifdef CDC_CMD_FEEDER_COALESCE_EN
   // Find the youngest live entry with the offered address; the head being
   // popped this cycle is leaving, so it is never a coalescing target.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((LW'(i) < level) && !(pop && (i == 0)) &&
             (addr_mem[rd_ptr + PW'(i)] == wr_addr)) begin
            hit     = 1'b1;
            hit_idx = rd_ptr + PW'(i);
         end
      end
   end

   assign wr_ready = !full || hit;
`else
   assign hit      = 1'b0;
   assign hit_idx  = '0;
   assign wr_ready = !full;
`endif

   assign accept    = wr_valid && wr_ready;
   assign push      = accept && !hit;
   assign overwrite = accept && hit;

   // Storage carries no reset; only entries below level are ever observed.
   always_ff @(posedge src_clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= wr_addr;
         data_mem[wr_ptr] <= wr_data;
      end else if (overwrite) begin
         data_mem[hit_idx] <= wr_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two; a push and pop
   // together leave the occupancy unchanged.
   always_ff @(posedge src_clk or negedge src_resetn) begin
      if (!src_resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            level <= level + LW'(1);
         end else if (pop && !push) begin
            level <= level - LW'(1);
         end
      end
   end

endmodule

// File: rtl/cdc_cmd_feeder.sv
// Feeds queued commands into a pulse-launched clock-domain crossing.
// Optional write coalescing is enabled by defining CDC_CMD_FEEDER_COALESCE_EN.
module cdc_cmd_feeder
   import cdc_cmd_feeder_pkg::*;
#(
   parameter int AW    = AW_DEFAULT,
   parameter int DW    = DW_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                     src_clk,
   input  logic                     src_resetn,
   input  logic                     wr_valid,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DW-1:0]            wr_data,
   output logic                     wr_ready,
   input  logic                     src_busy,
   output logic                     src_send,
   output logic [AW+DW-1:0]         src_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty
);

   feeder_state_t    state;
   feeder_state_t    state_next;
   logic             pop;
   logic [AW+DW-1:0] head;

   cdc_cmd_fifo #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .src_clk    (src_clk),
      .src_resetn (src_resetn),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .pop        (pop),
      .head       (head),
      .level      (level),
      .empty      (empty)
   );

   // Launch FSM state register.
   always_ff @(posedge src_clk or negedge src_resetn) begin
      if (!src_resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Launch only from IDLE with a free crossing; GUARD ignores busy because
   // the crossing raises it one cycle after the pulse.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !src_busy) begin
               state_next = SEND;
               pop        = 1'b1;
            end
         end
         SEND:    state_next = GUARD;
         GUARD:   state_next = WAIT;
         WAIT: begin
            if (!src_busy) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Capture the head on launch; the pulse covers exactly the SEND cycle and
   // the data holds until the next launch.
   always_ff @(posedge src_clk or negedge src_resetn) begin
      if (!src_resetn) begin
         src_send <= 1'b0;
         src_data <= '0;
      end else begin
         src_send <= pop;
         if (pop) begin
            src_data <= head;
         end
      end
   end

endmodule

// File: tb/tb_cdc_cmd_feeder.sv
// Self-checking bench for cdc_cmd_feeder: directed scenarios plus random
// traffic, all compared each cycle against a queue-based reference model.
module tb_cdc_cmd_feeder;
   import cdc_cmd_feeder_pkg::*;

   localparam int AW    = AW_DEFAULT;
   localparam int DW    = DW_DEFAULT;
   localparam int DEPTH = DEPTH_DEFAULT;

   logic                   src_clk;
   logic                   src_resetn;
   logic                   wr_valid;
   logic [AW-1:0]          wr_addr;
   logic [DW-1:0]          wr_data;
   logic                   wr_ready;
   logic                   src_busy;
   logic                   src_send;
   logic [AW+DW-1:0]       src_data;
   logic [$clog2(DEPTH):0] level;
   logic                   empty;

   int   checkCount = 0;
   int   failCount  = 0;

   cmd_t modelQ[$];
   cmd_t lastSent;
   bit   idleOk;
   bit   sendNow;
   bit   launchedLast;
   int   cyc;
   int   checkFrom;
   int   busyFrom;
   int   busyTo;
   int   busyMode;
   logic manualBusy;
   int   prevSend;
   int   obsCyc[$];
   cmd_t obsData[$];
   int   sampLevel;
   int   sampReady;
   int   sampSend;
   int   markCyc;

   cdc_cmd_feeder #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (DEPTH)
   ) dut (
      .src_clk    (src_clk),
      .src_resetn (src_resetn),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .src_busy   (src_busy),
      .src_send   (src_send),
      .src_data   (src_data),
      .level      (level),
      .empty      (empty)
   );

   // Free-running source clock.
   initial begin
      src_clk = 1'b0;
      forever #5 src_clk = ~src_clk;
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic clearModel();
      modelQ.delete();
      lastSent     = '0;
      idleOk       = 1'b1;
      sendNow      = 1'b0;
      launchedLast = 1'b0;
      checkFrom    = 0;
      busyFrom     = -10;
      busyTo       = -10;
      prevSend     = -1;
   endtask

   // One cycle: drive inputs at the falling edge, check the DUT against the
   // model, then advance the model across the next rising edge.
   task automatic applyStimulus(input logic v, input logic [AW-1:0] a,
                                input logic [DW-1:0] d);
      bit launch;
      bit found;
      bit expReady;
      int j;
      @(negedge src_clk);
      wr_valid = v;
      wr_addr  = a;
      wr_data  = d;
      case (busyMode)
         1:       src_busy = (cyc >= busyFrom) && (cyc <= busyTo);
         2:       src_busy = ($urandom_range(0, 3) == 0);
         default: src_busy = manualBusy;
      endcase
      #1;
      launch = idleOk && (modelQ.size() > 0) && !src_busy;
      found  = 1'b0;
      j      = 0;
`ifdef CDC_CMD_FEEDER_COALESCE_EN
      for (int k = (launch ? 1 : 0); k < modelQ.size(); k++) begin
         if (modelQ[k].addr == a) begin
            found = 1'b1;
            j     = k;
         end
      end
`endif
      expReady = (modelQ.size() < DEPTH) || found;
      sampLevel = int'(level);
      sampReady = int'(wr_ready);
      sampSend  = int'(src_send);
      checkOutput("wr_ready", 32'(wr_ready), 32'(expReady));
      checkOutput("src_send", 32'(src_send), 32'(sendNow));
      checkOutput("src_data", 32'(src_data), 32'(lastSent));
      checkOutput("level", 32'(level), 32'(modelQ.size()));
      checkOutput("empty", 32'(empty), 32'(modelQ.size() == 0));
      if (src_send === 1'b1) begin
         if (prevSend >= 0) begin
            checkOutput("spacing_ge4", 32'((cyc - prevSend) >= 4), 32'd1);
         end
         prevSend = cyc;
         obsCyc.push_back(cyc);
         obsData.push_back(cmd_t'(src_data));
      end
      if (v && expReady) begin
         if (found) begin
            modelQ[j].data = d;
         end else begin
            modelQ.push_back(cmd_t'({a, d}));
         end
      end
      sendNow = launch;
      if (launch) begin
         lastSent  = modelQ.pop_front();
         idleOk    = 1'b0;
         checkFrom = cyc + 3;
         busyFrom  = cyc + 2;
         busyTo    = cyc + 7;
      end else if (!idleOk && (cyc >= checkFrom) && !src_busy) begin
         idleOk = 1'b1;
      end
      launchedLast = launch;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, '0, '0);
      end
   endtask

   task automatic doReset();
      @(negedge src_clk);
      src_resetn = 1'b0;
      wr_valid   = 1'b0;
      #1;
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_send", 32'(src_send), 32'd0);
      checkOutput("rst_data", 32'(src_data), 32'd0);
      checkOutput("rst_ready", 32'(wr_ready), 32'd1);
      checkOutput("rst_state", 32'(dut.state), 32'd0);
      clearModel();
      @(negedge src_clk);
      #2;
      src_resetn = 1'b1;
      cyc++;
   endtask

   initial begin
      src_resetn = 1'b0;
      wr_valid   = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      src_busy   = 1'b0;
      busyMode   = 0;
      manualBusy = 1'b0;
      cyc        = 0;
      clearModel();
      doReset();

      // Single write reaches the crossing two cycles after acceptance.
      obsCyc.delete(); obsData.delete();
      markCyc = cyc;
      applyStimulus(1'b1, 4'd3, 8'hA5);
      idle(8);
      checkOutput("s1_count", 32'(obsCyc.size()), 32'd1);
      if (obsCyc.size() > 0) begin
         checkOutput("s1_data", 32'(obsData[0]), 32'h3A5);
         checkOutput("s1_latency", 32'(obsCyc[0] - markCyc), 32'd2);
      end

      // Burst fills the queue while busy, then drains through a modelled crossing.
      obsCyc.delete(); obsData.delete();
      manualBusy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, AW'(i + 1), DW'(8'h11 * (i + 1)));
      end
      applyStimulus(1'b1, 4'd9, 8'h99);
      checkOutput("s2_level_full", 32'(sampLevel), 32'd4);
      checkOutput("s2_ready_full", 32'(sampReady), 32'd0);
      busyMode = 1;
      idle(50);
      checkOutput("s2_count", 32'(obsCyc.size()), 32'd4);
      for (int i = 0; i < 4 && i < obsCyc.size(); i++) begin
         checkOutput("s2_order", 32'(obsData[i]), 32'(((i + 1) << 8) | (8'h11 * (i + 1))));
      end

      // Busy held high blocks launches; first pulse one cycle after it drops.
      busyMode   = 0;
      manualBusy = 1'b1;
      obsCyc.delete(); obsData.delete();
      applyStimulus(1'b1, 4'd2, 8'h5A);
      applyStimulus(1'b1, 4'd7, 8'hC3);
      idle(20);
      checkOutput("s3_none", 32'(obsCyc.size()), 32'd0);
      manualBusy = 1'b0;
      markCyc = cyc;
      idle(12);
      checkOutput("s3_count", 32'(obsCyc.size()), 32'd2);
      if (obsCyc.size() > 0) begin
         checkOutput("s3_first", 32'(obsCyc[0] - markCyc), 32'd1);
      end

      // Repeated address while busy: coalesced when the feature is built in.
      manualBusy = 1'b1;
      obsCyc.delete(); obsData.delete();
      applyStimulus(1'b1, 4'd5, 8'h10);
      applyStimulus(1'b1, 4'd6, 8'h20);
      applyStimulus(1'b1, 4'd5, 8'h30);
      idle(1);
`ifdef CDC_CMD_FEEDER_COALESCE_EN
      checkOutput("s4_level", 32'(sampLevel), 32'd2);
`else
      checkOutput("s4_level", 32'(sampLevel), 32'd3);
`endif
      manualBusy = 1'b0;
      idle(20);
`ifdef CDC_CMD_FEEDER_COALESCE_EN
      checkOutput("s4_count", 32'(obsCyc.size()), 32'd2);
      if (obsCyc.size() >= 2) begin
         checkOutput("s4_send0", 32'(obsData[0]), 32'h530);
         checkOutput("s4_send1", 32'(obsData[1]), 32'h620);
      end
`else
      checkOutput("s4_count", 32'(obsCyc.size()), 32'd3);
      if (obsCyc.size() >= 3) begin
         checkOutput("s4_send0", 32'(obsData[0]), 32'h510);
         checkOutput("s4_send1", 32'(obsData[1]), 32'h620);
         checkOutput("s4_send2", 32'(obsData[2]), 32'h530);
      end
`endif

      // Reset in GUARD with three entries still queued discards everything.
      manualBusy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, AW'(i + 8), DW'($urandom));
      end
      manualBusy = 1'b0;
      for (int i = 0; i < 10 && !launchedLast; i++) begin
         applyStimulus(1'b0, '0, '0);
      end
      applyStimulus(1'b0, '0, '0);
      checkOutput("s5_send", 32'(sampSend), 32'd1);
      checkOutput("s5_level", 32'(sampLevel), 32'd3);
      doReset();
      obsCyc.delete(); obsData.delete();
      idle(20);
      checkOutput("s5_no_send", 32'(obsCyc.size()), 32'd0);

      // Random traffic with random busy, then with the modelled crossing.
      busyMode = 2;
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 99) < 60), AW'($urandom_range(0, 3)), DW'($urandom));
      end
      busyMode = 1;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(($urandom_range(0, 99) < 40), AW'($urandom_range(0, 5)), DW'($urandom));
      end
      busyMode   = 0;
      manualBusy = 1'b0;
      idle(40);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/cdc_cmd_feeder.md
CDC_CMD_FEEDER -- requirements
Module: cdc_cmd_feeder

Interface
REQ-001 The block SHALL have parameter AW, default 4, meaning command address width.
REQ-002 The block SHALL have parameter DW, default 8, meaning command data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning queue entries, a power of two, at least 2.
REQ-004 The block SHALL have port src_clk, input, 1, the clock; reset src_resetn, asynchronous, active-low; clock src_clk.
REQ-005 The block SHALL have port src_resetn, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port wr_valid, input, 1, meaning a command is offered.
REQ-007 The block SHALL have port wr_addr, input, AW, meaning the command address.
REQ-008 The block SHALL have port wr_data, input, DW, meaning the command data.
REQ-009 The block SHALL have port wr_ready, output, 1, meaning the command is accepted this cycle.
REQ-010 The block SHALL have port src_busy, input, 1, meaning the downstream crossing is occupied.
REQ-011 The block SHALL have port src_send, output, 1, a 1-cycle launch pulse to the crossing.
REQ-012 The block SHALL have port src_data, output, AW+DW, carrying {addr,data} to the crossing.
REQ-013 The block SHALL have port level, output, clog2(DEPTH)+1, meaning the occupied entries.
REQ-014 The block SHALL have port empty, output, 1, meaning level is 0.

Function
REQ-015 The block SHALL accept a write on each src_clk edge where wr_valid and wr_ready are both 1; wr_ready is combinational.
REQ-016 Without coalescing, the block SHALL drive wr_ready = (level != DEPTH).
REQ-017 A pop in the same cycle SHALL NOT free space for the push in that cycle.
REQ-018 The queue SHALL be FIFO-ordered, with read and write pointers that wrap modulo DEPTH.
REQ-019 The block SHALL implement FSM IDLE, SEND, GUARD, WAIT:
- IDLE -> SEND when !empty and !src_busy.
- SEND -> GUARD unconditionally.
- GUARD -> WAIT unconditionally.
- WAIT -> IDLE when !src_busy.
REQ-020 On the IDLE->SEND edge, the block SHALL register the head into src_data, pop the head, and set src_send=1 for exactly the SEND cycle.
REQ-021 src_data SHALL hold its value until the next SEND.
REQ-022 The block SHALL ignore src_busy during GUARD, which covers the one-cycle delay before the crossing raises busy.
REQ-023 Latency: a write accepted on edge k into an empty queue in IDLE with src_busy=0 SHALL produce src_send high between edges k+1 and k+2.
REQ-024 Minimum spacing between successive src_send pulses SHALL be 4 cycles.
REQ-025 On a simultaneous push and pop, level SHALL be unchanged and the pushed entry SHALL be enqueued behind the remaining entries.
REQ-026 If src_busy is 1 in IDLE, the block SHALL stay in IDLE with the queue held.

Reset
REQ-027 On src_resetn low, the block SHALL asynchronously set the FSM to IDLE, both pointers to 0, level=0, empty=1, src_send=0 and src_data=0.
REQ-028 A reset mid-handshake SHALL discard all queued and in-flight commands with no partial pulse.
REQ-029 Queue storage SHALL need no reset.

Configuration
REQ-030 Macro CDC_CMD_FEEDER_COALESCE_EN SHALL control write coalescing.
REQ-031 When CDC_CMD_FEEDER_COALESCE_EN is defined:
- An accepted write whose wr_addr matches a valid queued entry overwrites that entry's data in place; level and order are unchanged.
- The entry being popped in the same cycle is excluded from matching, so such a write enqueues normally.
- wr_ready = (level != DEPTH) or match, so a matching write is accepted even when the queue is full.
- If several entries match, only the youngest is updated.
REQ-032 When CDC_CMD_FEEDER_COALESCE_EN is undefined, the block SHALL have no address comparators and SHALL behave strictly per REQ-016.

Structure
REQ-033 Package cdc_cmd_feeder_pkg SHALL hold:
- the AW, DW and DEPTH defaults;
- the FSM state type with encoding IDLE=0, SEND=1, GUARD=2, WAIT=3;
- the packed command type {addr,data}.
REQ-034 Sub-module cdc_cmd_fifo SHALL contain the storage, the pointers, level, and the coalesce match logic.
REQ-035 The top level SHALL contain only the FSM and the output registers.

Verification
REQ-036 Scenario, single write: write addr=3, data=0xA5 with src_busy=0 -> one src_send pulse 2 cycles later with src_data=0x3A5.
REQ-037 Scenario, burst: burst of 4 writes (0x11, 0x22, 0x33, 0x44) -> level reaches 4 and wr_ready=0. The bench models busy as 1 from 1 cycle after each send for 6 cycles. Expect 4 pulses in order, each at least 4 cycles apart.
REQ-038 Scenario, held busy: src_busy held at 1 for 20 cycles with 2 entries queued -> no src_send. After busy falls, the first pulse follows 1 cycle later.
REQ-039 Scenario, coalescing (macro defined): writes (5,0x10), (6,0x20), (5,0x30) while busy -> level=2, and sends are 0x530 then 0x620. With the macro undefined, the same stimulus gives 3 sends in order.
REQ-040 Scenario, reset: assert src_resetn low during GUARD with 3 queued -> level=0, src_send=0, IDLE. No sends occur after release without new writes.
